// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control encodings, state type and per-state control word for the multicycle MIPS controller.
// Pure definitions: no latency, no flow control.
package multicycle_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;

    localparam logic [1:0] ALU_OP_ADD     = 2'b00;
    localparam logic [1:0] ALU_OP_SUB     = 2'b01;
    localparam logic [1:0] ALU_OP_LUI     = 2'b10;
    localparam logic [1:0] ALU_OP_SLT_MUL = 2'b11;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_I_EXEC    = 4'd9,
        ST_I_WB      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_TRAP      = 4'd13
    } state_t;

    // ready_qual marks the one state whose PC/IR writes must wait for Mem_Ready.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ready_qual;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [5:0] alu_funct;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic ctrl_t ctrl_for_state(input state_t st,
                                             input logic [1:0] alu_op,
                                             input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            ST_FETCH: begin
                c.mem_read   = 1'b1;
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.ready_qual = 1'b1;
                c.alu_src_b  = SRC_B_FOUR;
                c.pc_source  = PC_SRC_ALU;
                c.alu_op     = ALU_OP_ADD;
            end
            ST_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH;
                c.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = alu_op;
                c.alu_funct = funct;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = alu_op;
                c.alu_funct = funct;
            end
            // ALU_Funct stays 0 so slti's Op 11 can never be read as mult downstream.
            ST_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = alu_op;
            end
            ST_I_WB: begin
                c.reg_write = 1'b1;
                c.alu_op    = alu_op;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRC_B_REG;
                c.alu_op        = ALU_OP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
            end
            ST_TRAP: begin
                c.illegal = 1'b1;
            end
            default: begin
                c = CTRL_IDLE;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Classifies the held instruction word into an execution path and its ALU_Op.
// Purely combinational, zero latency; no flow control.
module multicycle_control_fsm_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_rtype,
    output logic       is_itype,
    output logic       is_branch,
    output logic       is_jump,
    output logic [1:0] alu_op
);

    always_comb begin
        is_mem    = 1'b0;
        is_load   = 1'b0;
        is_rtype  = 1'b0;
        is_itype  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        alu_op    = ALU_OP_ADD;
        case (opcode)
            // R-type functions other than add/mult fall through as illegal.
            OP_RTYPE: begin
                if (funct == FN_ADD) begin
                    is_rtype = 1'b1;
                end else if (funct == FN_MULT) begin
                    is_rtype = 1'b1;
                    alu_op   = ALU_OP_SLT_MUL;
                end
            end
            OP_ADDI: begin
                is_itype = 1'b1;
            end
            OP_SLTI: begin
                is_itype = 1'b1;
                alu_op   = ALU_OP_SLT_MUL;
            end
            OP_LUI: begin
                is_itype = 1'b1;
                alu_op   = ALU_OP_LUI;
            end
            OP_LW: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OP_SW: begin
                is_mem = 1'b1;
            end
            OP_BEQ: begin
                is_branch = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            default: begin
                is_mem = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, feeds ALU_Decoder.
// 3-5 cycles per instruction; FETCH, MEM_READ and MEM_WRITE hold until Mem_Ready, each low cycle adds one.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       PC_En,
    output logic       IorD,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       IR_Write,
    output logic       Reg_Dst,
    output logic       Mem_to_Reg,
    output logic       Reg_Write,
    output logic       ALU_Src_A,
    output logic [1:0] ALU_Src_B,
    output logic [1:0] PC_Source,
    output logic [1:0] ALU_Op,
    output logic [5:0] ALU_Funct,
    output logic       Illegal_Instr
);

    state_t     state_q;
    state_t     state_nxt;
    ctrl_t      ctrl_q;

    logic       dec_is_mem;
    logic       dec_is_load;
    logic       dec_is_rtype;
    logic       dec_is_itype;
    logic       dec_is_branch;
    logic       dec_is_jump;
    logic [1:0] dec_alu_op;

    multicycle_control_fsm_decode u_decode (
        .opcode    (Opcode),
        .funct     (Funct),
        .is_mem    (dec_is_mem),
        .is_load   (dec_is_load),
        .is_rtype  (dec_is_rtype),
        .is_itype  (dec_is_itype),
        .is_branch (dec_is_branch),
        .is_jump   (dec_is_jump),
        .alu_op    (dec_alu_op)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:      state_nxt = ST_FETCH;
            ST_FETCH:     if (Mem_Ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (dec_is_mem)         state_nxt = ST_MEM_ADDR;
                else if (dec_is_rtype)  state_nxt = ST_R_EXEC;
                else if (dec_is_itype)  state_nxt = ST_I_EXEC;
                else if (dec_is_branch) state_nxt = ST_BRANCH;
                else if (dec_is_jump)   state_nxt = ST_JUMP;
                else                    state_nxt = TRAP_ON_ILLEGAL ? ST_TRAP : ST_FETCH;
            end
            ST_MEM_ADDR:  state_nxt = dec_is_load ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (Mem_Ready) state_nxt = ST_MEM_WB;
            ST_MEM_WB:    state_nxt = ST_FETCH;
            ST_MEM_WRITE: if (Mem_Ready) state_nxt = ST_FETCH;
            ST_R_EXEC:    state_nxt = ST_R_WB;
            ST_R_WB:      state_nxt = ST_FETCH;
            ST_I_EXEC:    state_nxt = ST_I_WB;
            ST_I_WB:      state_nxt = ST_FETCH;
            ST_BRANCH:    state_nxt = ST_FETCH;
            ST_JUMP:      state_nxt = ST_FETCH;
            ST_TRAP:      state_nxt = ST_TRAP;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // The control word is registered together with the state it belongs to, so outputs are glitch-free
    // and cleared the instant reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= ctrl_for_state(state_nxt, dec_alu_op, Funct);
        end
    end

    assign PC_En         = (ctrl_q.pc_write & (~ctrl_q.ready_qual | Mem_Ready))
                         | (ctrl_q.pc_write_cond & Zero);
    assign IR_Write      = ctrl_q.ir_write & Mem_Ready;
    assign IorD          = ctrl_q.iord;
    assign Mem_Read      = ctrl_q.mem_read;
    assign Mem_Write     = ctrl_q.mem_write;
    assign Reg_Dst       = ctrl_q.reg_dst;
    assign Mem_to_Reg    = ctrl_q.mem_to_reg;
    assign Reg_Write     = ctrl_q.reg_write;
    assign ALU_Src_A     = ctrl_q.alu_src_a;
    assign ALU_Src_B     = ctrl_q.alu_src_b;
    assign PC_Source     = ctrl_q.pc_source;
    assign ALU_Op        = ctrl_q.alu_op;
    assign ALU_Funct     = ctrl_q.alu_funct;
    assign Illegal_Instr = ctrl_q.illegal;

    a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset) !(Mem_Read && Mem_Write));
    a_no_rw_pc: assert property (@(posedge clk) disable iff (!reset) !(Reg_Write && PC_En));

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Random instruction stream against an instruction-level micro-step model; a second DUT runs with illegal-as-NOP.
// Random Mem_Ready stalls, Zero values, mid-instruction resets and trap-then-reset recovery.
module tb_multicycle_control_fsm;

    localparam logic [21:0] PC_EN_BIT = 22'h1 << 21;
    localparam logic [21:0] IRW_BIT   = 22'h1 << 17;
    localparam int          N_CYCLES  = 6000;

    typedef struct packed {
        logic [21:0] vec;
        logic        hold;
        logic        rdy_fire;
        logic        zero_pc;
        logic        trap;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Opcode = 6'h0;
    logic [5:0] Funct = 6'h0;
    logic       Zero = 1'b0;
    logic       Mem_Ready = 1'b0;

    logic       PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A;
    logic [1:0] ALU_Src_B, PC_Source, ALU_Op;
    logic [5:0] ALU_Funct;
    logic       Illegal_Instr;

    logic       n_PC_En, n_IorD, n_Mem_Read, n_Mem_Write, n_IR_Write, n_Reg_Dst, n_Mem_to_Reg, n_Reg_Write;
    logic       n_ALU_Src_A;
    logic [1:0] n_ALU_Src_B, n_PC_Source, n_ALU_Op;
    logic [5:0] n_ALU_Funct;
    logic       n_Illegal_Instr;

    logic [21:0] obs, obs_nop;

    step_t  prog[$];
    string  prog_name[$];
    int     vec_cnt = 0;
    int     err_cnt = 0;
    int     trap_cnt = 0;
    int     stall_left = 0;
    bit     nop_sync = 1'b1;
    bit     force_rst = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PC_En(PC_En), .IorD(IorD), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
        .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write), .ALU_Src_A(ALU_Src_A),
        .ALU_Src_B(ALU_Src_B), .PC_Source(PC_Source), .ALU_Op(ALU_Op), .ALU_Funct(ALU_Funct),
        .Illegal_Instr(Illegal_Instr)
    );

    multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PC_En(n_PC_En), .IorD(n_IorD), .Mem_Read(n_Mem_Read), .Mem_Write(n_Mem_Write),
        .IR_Write(n_IR_Write), .Reg_Dst(n_Reg_Dst), .Mem_to_Reg(n_Mem_to_Reg), .Reg_Write(n_Reg_Write),
        .ALU_Src_A(n_ALU_Src_A), .ALU_Src_B(n_ALU_Src_B), .PC_Source(n_PC_Source), .ALU_Op(n_ALU_Op),
        .ALU_Funct(n_ALU_Funct), .Illegal_Instr(n_Illegal_Instr)
    );

    assign obs = {PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
                  ALU_Src_A, ALU_Src_B, PC_Source, ALU_Op, ALU_Funct, Illegal_Instr};
    assign obs_nop = {n_PC_En, n_IorD, n_Mem_Read, n_Mem_Write, n_IR_Write, n_Reg_Dst, n_Mem_to_Reg,
                      n_Reg_Write, n_ALU_Src_A, n_ALU_Src_B, n_PC_Source, n_ALU_Op, n_ALU_Funct,
                      n_Illegal_Instr};

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%06h exp=%06h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Field order matches the obs packing above.
    function automatic logic [21:0] ov(input bit pc_en, input bit iord, input bit mrd, input bit mwr,
                                       input bit irw, input bit rdst, input bit m2r, input bit rw,
                                       input bit sa, input logic [1:0] sb, input logic [1:0] pcs,
                                       input logic [1:0] op, input logic [5:0] fn, input bit ill);
        return {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, pcs, op, fn, ill};
    endfunction

    function automatic logic [21:0] fetch_vec();
        return ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 6'h00, 0);
    endfunction

    function automatic bit supported(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h0F, 6'h23, 6'h2B};
    endfunction

    task automatic push(input string nm, input logic [21:0] vec, input bit hold, input bit rdy_fire,
                        input bit zero_pc, input bit trap);
        step_t s;
        s.vec = vec;
        s.hold = hold;
        s.rdy_fire = rdy_fire;
        s.zero_pc = zero_pc;
        s.trap = trap;
        prog.push_back(s);
        prog_name.push_back(nm);
    endtask

    task automatic load_instr();
        int          pick;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [1:0]  aop;
        pick = $urandom_range(0, 39);
        fn = 6'($urandom_range(0, 63));
        push("fetch", fetch_vec(), 1, 1, 0, 0);
        push("decode", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 6'h00, 0), 0, 0, 0, 0);
        if (pick < 36) begin
            case (pick / 4)
                0, 1: begin
                    op = 6'h00;
                    fn = (pick / 4 == 0) ? 6'h20 : 6'h18;
                    aop = (fn == 6'h20) ? 2'b00 : 2'b11;
                    push("r_exec", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, aop, fn, 0), 0, 0, 0, 0);
                    push("r_wb", ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, aop, fn, 0), 0, 0, 0, 0);
                end
                2, 3, 4: begin
                    if (pick / 4 == 2) begin op = 6'h08; aop = 2'b00; end
                    else if (pick / 4 == 3) begin op = 6'h0A; aop = 2'b11; end
                    else begin op = 6'h0F; aop = 2'b10; end
                    if (pick % 2 == 0) fn = 6'h18;
                    push("i_exec", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, aop, 6'h00, 0), 0, 0, 0, 0);
                    push("i_wb", ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, aop, 6'h00, 0), 0, 0, 0, 0);
                end
                5: begin
                    op = 6'h23;
                    if (pick % 2 == 0) stall_left = 3;
                    push("lw_addr", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 6'h00, 0), 0, 0, 0, 0);
                    push("lw_read", ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 6'h00, 0), 1, 0, 0, 0);
                    push("lw_wb", ov(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 6'h00, 0), 0, 0, 0, 0);
                end
                6: begin
                    op = 6'h2B;
                    push("sw_addr", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 6'h00, 0), 0, 0, 0, 0);
                    push("sw_write", ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 6'h00, 0), 1, 0, 0, 0);
                end
                7: begin
                    op = 6'h04;
                    push("beq", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 6'h00, 0), 0, 0, 1, 0);
                end
                default: begin
                    op = 6'h02;
                    push("jump", ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 6'h00, 0), 0, 0, 0, 0);
                end
            endcase
        end else begin
            if (pick < 38) begin
                op = 6'h00;
                while (fn == 6'h20 || fn == 6'h18) fn = 6'($urandom_range(0, 63));
            end else if (pick == 38) begin
                op = 6'h3F;
            end else begin
                op = 6'($urandom_range(0, 63));
                while (supported(op)) op = 6'($urandom_range(0, 63));
            end
            push("trap", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 6'h00, 1), 1, 0, 0, 1);
        end
        Opcode = op;
        Funct = fn;
    endtask

    // Called at a falling edge; returns at the falling edge where reset is released.
    task automatic do_reset(input int hold_cycles);
        reset = 1'b0;
        Mem_Ready = 1'b0;
        #1;
        check("rst_drop", obs, 22'h0);
        check("rst_drop_nop", obs_nop, 22'h0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            Mem_Ready = 1'b0;
            #1;
            check("rst_hold", obs, 22'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        prog.delete();
        prog_name.delete();
        push("idle", 22'h0, 0, 0, 0, 0);
        nop_sync = 1'b1;
        trap_cnt = 0;
        stall_left = 0;
        force_rst = 1'b0;
    endtask

    initial begin
        step_t       cur;
        string       nm;
        logic [21:0] exp;
        logic [21:0] nexp;
        @(negedge clk);
        do_reset(3);
        for (int c = 0; c < N_CYCLES; c++) begin
            if (c > 0) @(negedge clk);
            if (force_rst || (c > 0 && trap_cnt == 0 && $urandom_range(0, 99) == 0))
                do_reset($urandom_range(1, 3));
            if (prog.size() == 0) load_instr();
            cur = prog[0];
            nm = prog_name[0];
            if (cur.hold && !cur.rdy_fire && !cur.trap && stall_left > 0) begin
                Mem_Ready = 1'b0;
                stall_left--;
            end else begin
                Mem_Ready = ($urandom_range(0, 3) != 0);
            end
            Zero = 1'($urandom_range(0, 1));
            #1;
            exp = cur.vec;
            if (cur.rdy_fire && Mem_Ready) exp = exp | PC_EN_BIT | IRW_BIT;
            if (cur.zero_pc && Zero) exp = exp | PC_EN_BIT;
            check({"main_", nm}, obs, exp);
            if (nop_sync) begin
                if (cur.trap) begin
                    nexp = fetch_vec();
                    if (Mem_Ready) nexp = nexp | PC_EN_BIT | IRW_BIT;
                    check("nop_illegal_to_fetch", obs_nop, nexp);
                    nop_sync = 1'b0;
                end else begin
                    check({"nop_", nm}, obs_nop, exp);
                end
            end
            if (cur.trap) begin
                trap_cnt++;
                if (trap_cnt >= 20) force_rst = 1'b1;
            end else if (!(cur.hold && !Mem_Ready)) begin
                void'(prog.pop_front());
                void'(prog_name.pop_front());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
